// File: rtl/rotary_bcd_counter_if.sv
// Encoder inputs and BCD digit / step pulse outputs of the rotary BCD counter.
interface rotary_bcd_counter_if;
    logic       enc_a;
    logic       enc_b;
    logic       enc_sw;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       step_up;
    logic       step_dn;
    logic       count_wrap;

    modport master (
        output enc_a, enc_b, enc_sw,
        input  digit0, digit1, digit2, digit3, step_up, step_dn, count_wrap
    );

    modport slave (
        input  enc_a, enc_b, enc_sw,
        output digit0, digit1, digit2, digit3, step_up, step_dn, count_wrap
    );
endinterface

// File: rtl/rotary_bcd_counter.sv
// Rotary encoder front end (sync, debounce, quadrature decode) driving a
// 4-digit BCD up/down counter that feeds the 7-segment scan stage.
module rotary_bcd_counter #(
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned STEPS_PER_DETENT = 4
) (
    input logic                 clk,
    input logic                 rst,
    rotary_bcd_counter_if.slave bus
);
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ACC_W  = 4;
    localparam int unsigned N_IN   = 3;
    localparam int unsigned N_DIG  = 4;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(STEPS_PER_DETENT);

    // Bit 2 = A, bit 1 = B, bit 0 = push switch.
    logic [N_IN-1:0]  w_raw;
    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [N_IN-1:0]  r_stable;
    logic [CNT_W-1:0] r_db_cnt [N_IN];

    logic [1:0]              w_ab;
    logic [1:0]              r_prev_ab;
    logic signed [ACC_W-1:0] w_delta;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_step_up;
    logic                    r_step_dn;

    logic       r_prev_sw;
    logic       w_press;
    logic [3:0] r_digit [N_DIG];
    logic [3:0] w_inc   [N_DIG];
    logic [3:0] w_dec   [N_DIG];
    logic       w_inc_wrap;
    logic       w_dec_wrap;
    logic       r_wrap;

    assign w_raw = {bus.enc_a, bus.enc_b, bus.enc_sw};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stable value flips only after the input has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '1;
            for (int i = 0; i < N_IN; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_ab = r_stable[2:1];

    always_comb begin
        w_delta = '0;
        case ({r_prev_ab, w_ab})
            4'b1110, 4'b1000, 4'b0001, 4'b0111: w_delta = 4'sd1;
            4'b1101, 4'b0100, 4'b0010, 4'b1011: w_delta = -4'sd1;
            default:                            w_delta = '0;
        endcase
        w_acc_sum = r_acc + w_delta;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_ab <= 2'b11;
            r_acc     <= '0;
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
        end else begin
            r_prev_ab <= w_ab;
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            if (w_acc_sum == ACC_MAX) begin
                r_step_up <= 1'b1;
                r_acc     <= '0;
            end else if (w_acc_sum == -ACC_MAX) begin
                r_step_dn <= 1'b1;
                r_acc     <= '0;
            end else begin
                r_acc <= w_acc_sum;
            end
        end
    end

    assign w_press = r_prev_sw & ~r_stable[0];

    // Ripple carry/borrow through the BCD digits; carry out of the top digit is the wrap.
    always_comb begin
        logic w_carry;
        logic w_borrow;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            w_inc[i] = r_digit[i];
            w_dec[i] = r_digit[i];
            if (w_carry) begin
                if (r_digit[i] == 4'd9) begin
                    w_inc[i] = 4'd0;
                end else begin
                    w_inc[i] = r_digit[i] + 4'd1;
                    w_carry  = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_digit[i] == 4'd0) begin
                    w_dec[i] = 4'd9;
                end else begin
                    w_dec[i] = r_digit[i] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
        end
        w_inc_wrap = w_carry;
        w_dec_wrap = w_borrow;
    end

    // A press overrides a step resolving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIG; i++) r_digit[i] <= '0;
            r_wrap    <= 1'b0;
            r_prev_sw <= 1'b1;
        end else begin
            r_prev_sw <= r_stable[0];
            r_wrap    <= 1'b0;
            if (w_press) begin
                for (int i = 0; i < N_DIG; i++) r_digit[i] <= '0;
            end else if (r_step_up) begin
                for (int i = 0; i < N_DIG; i++) r_digit[i] <= w_inc[i];
                r_wrap <= w_inc_wrap;
            end else if (r_step_dn) begin
                for (int i = 0; i < N_DIG; i++) r_digit[i] <= w_dec[i];
                r_wrap <= w_dec_wrap;
            end
        end
    end

    assign bus.digit0     = r_digit[0];
    assign bus.digit1     = r_digit[1];
    assign bus.digit2     = r_digit[2];
    assign bus.digit3     = r_digit[3];
    assign bus.step_up    = r_step_up;
    assign bus.step_dn    = r_step_dn;
    assign bus.count_wrap = r_wrap;

endmodule

// File: tb/tb_rotary_bcd_counter.sv
// Bench for rotary_bcd_counter: directed scenarios plus a random encoder walk
// checked against a position/count model of the encoder and BCD counter.
module tb_rotary_bcd_counter;
    localparam int unsigned DB   = 4;
    localparam int unsigned SPD  = 4;
    localparam int          HOLD = 12;
    localparam int          T_STEP  = 2 + DB + 1;
    localparam int          T_DIGIT = 2 + DB + 2;

    logic clk = 1'b0;
    logic rst;

    rotary_bcd_counter_if bus ();

    rotary_bcd_counter #(
        .DEBOUNCE_CYCLES  (DB),
        .STEPS_PER_DETENT (SPD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int n_up = 0, n_dn = 0, n_wrap = 0, n_wide = 0, n_both = 0, n_badbcd = 0;
    logic p_up = 1'b0, p_dn = 1'b0, p_wrap = 1'b0;

    int   m_count, m_acc, exp_up, exp_dn, exp_wrap;
    logic m_a, m_b;
    int   up_at, dn_at, wrap_at, chg_at;

    // Pulse monitor: counts pulses, pulses wider than one cycle, and bad BCD.
    always @(negedge clk) begin
        if (bus.step_up === 1'b1) n_up++;
        if (bus.step_dn === 1'b1) n_dn++;
        if (bus.count_wrap === 1'b1) n_wrap++;
        if ((bus.step_up === 1'b1 && p_up) || (bus.step_dn === 1'b1 && p_dn) ||
            (bus.count_wrap === 1'b1 && p_wrap)) n_wide++;
        if (bus.step_up === 1'b1 && bus.step_dn === 1'b1) n_both++;
        if (rst === 1'b0 && (bus.digit0 > 4'd9 || bus.digit1 > 4'd9 ||
                             bus.digit2 > 4'd9 || bus.digit3 > 4'd9)) n_badbcd++;
        p_up   = (bus.step_up === 1'b1);
        p_dn   = (bus.step_dn === 1'b1);
        p_wrap = (bus.count_wrap === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int qpos(input logic a, input logic b);
        case ({a, b})
            2'b11:   return 0;
            2'b10:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b11;
            1:       return 2'b10;
            2:       return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [15:0] exp_digits(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    // Drive a new encoder state, record when pulses/digit changes appear, update model.
    task automatic drive_ab(input logic a, input logic b, input int hold);
        logic [15:0] d0;
        int          d;
        up_at = -1; dn_at = -1; wrap_at = -1; chg_at = -1;
        d0 = dut_digits();
        bus.enc_a = a;
        bus.enc_b = b;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (bus.step_up === 1'b1 && up_at < 0) up_at = k;
            if (bus.step_dn === 1'b1 && dn_at < 0) dn_at = k;
            if (bus.count_wrap === 1'b1 && wrap_at < 0) wrap_at = k;
            if (dut_digits() !== d0 && chg_at < 0) chg_at = k;
        end
        d = (qpos(a, b) - qpos(m_a, m_b) + 4) % 4;
        if (d == 1) m_acc++;
        if (d == 3) m_acc--;
        if (m_acc == int'(SPD)) begin
            m_acc = 0;
            exp_up++;
            m_count = (m_count + 1) % 10000;
            if (m_count == 0) exp_wrap++;
        end else if (m_acc == -int'(SPD)) begin
            m_acc = 0;
            exp_dn++;
            m_count = (m_count + 9999) % 10000;
            if (m_count == 9999) exp_wrap++;
        end
        m_a = a;
        m_b = b;
    endtask

    task automatic cw_detent();
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b0, 1'b1, HOLD);
        drive_ab(1'b1, 1'b1, HOLD);
    endtask

    task automatic ccw_detent();
        drive_ab(1'b0, 1'b1, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b1, 1'b1, HOLD);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enc_a = 1'b1; bus.enc_b = 1'b1; bus.enc_sw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_count = 0; m_acc = 0; m_a = 1'b1; m_b = 1'b1;
        exp_up = 0; exp_dn = 0; exp_wrap = 0;
        total++;
        if (dut_digits() !== 16'h0000) begin
            bad++; $display("FAIL reset_digits: got %h expected 0000", dut_digits());
        end
        total++;
        if ({bus.step_up, bus.step_dn, bus.count_wrap} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses: got %b expected 000",
                            {bus.step_up, bus.step_dn, bus.count_wrap});
        end
        repeat (50) @(posedge clk);
        #1;
        total++;
        if (n_up + n_dn + n_wrap !== 0) begin
            bad++; $display("FAIL reset_idle_pulses: got %0d expected 0", n_up + n_dn + n_wrap);
        end
    endtask

    task automatic test_wrap();
        ccw_detent();
        total++;
        if (dut_digits() !== exp_digits(m_count) || m_count != 9999) begin
            bad++; $display("FAIL wrap_down_digits: got %h expected %h", dut_digits(), exp_digits(m_count));
        end
        total++;
        if (n_wrap !== exp_wrap || wrap_at !== T_DIGIT) begin
            bad++; $display("FAIL wrap_down_pulse: got count %0d at %0d expected %0d at %0d",
                            n_wrap, wrap_at, exp_wrap, T_DIGIT);
        end
        cw_detent();
        total++;
        if (dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL wrap_up_digits: got %h expected %h", dut_digits(), exp_digits(m_count));
        end
        total++;
        if (n_wrap !== exp_wrap || wrap_at !== T_DIGIT) begin
            bad++; $display("FAIL wrap_up_pulse: got count %0d at %0d expected %0d at %0d",
                            n_wrap, wrap_at, exp_wrap, T_DIGIT);
        end
    endtask

    task automatic test_cw_detent();
        int up0;
        up0 = n_up;
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b0, 1'b1, HOLD);
        total++;
        if (n_up !== up0) begin
            bad++; $display("FAIL cw_early_step: got %0d pulses expected 0", n_up - up0);
        end
        drive_ab(1'b1, 1'b1, HOLD);
        total++;
        if (up_at !== T_STEP || chg_at !== T_DIGIT) begin
            bad++; $display("FAIL cw_latency: got pulse %0d digits %0d expected %0d %0d",
                            up_at, chg_at, T_STEP, T_DIGIT);
        end
        total++;
        if (n_up !== exp_up || dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL cw_one_step: got %0d pulses digits %h expected %0d %h",
                            n_up, dut_digits(), exp_up, exp_digits(m_count));
        end
        repeat (9) cw_detent();
        total++;
        if (dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL cw_carry: got %h expected %h", dut_digits(), exp_digits(m_count));
        end
        ccw_detent();
        total++;
        if (dut_digits() !== exp_digits(m_count) || n_dn !== exp_dn || dn_at !== T_STEP) begin
            bad++; $display("FAIL ccw_borrow: got %h dn %0d at %0d expected %h dn %0d at %0d",
                            dut_digits(), n_dn, dn_at, exp_digits(m_count), exp_dn, T_STEP);
        end
    endtask

    task automatic test_bounce();
        int up0, dn0, a_moved;
        up0 = n_up; dn0 = n_dn; a_moved = 0;
        for (int i = 0; i < 15; i++) begin
            bus.enc_a = ~bus.enc_a;
            repeat (2) begin
                @(posedge clk); #1;
                if (dut.r_stable[2] !== 1'b1) a_moved++;
            end
        end
        bus.enc_a = 1'b1;
        repeat (HOLD) begin
            @(posedge clk); #1;
            if (dut.r_stable[2] !== 1'b1) a_moved++;
        end
        total++;
        if (a_moved !== 0) begin
            bad++; $display("FAIL bounce_stable_a: got %0d moved cycles expected 0", a_moved);
        end
        total++;
        if (n_up !== up0 || n_dn !== dn0 || dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL bounce_no_step: got up %0d dn %0d digits %h expected %0d %0d %h",
                            n_up - up0, n_dn - dn0, dut_digits(), 0, 0, exp_digits(m_count));
        end
    endtask

    task automatic test_invalid();
        int up0, dn0;
        up0 = n_up; dn0 = n_dn;
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b1, 1'b1, HOLD);
        total++;
        if (n_up !== up0 || n_dn !== dn0) begin
            bad++; $display("FAIL invalid_no_step: got up %0d dn %0d expected 0 0", n_up - up0, n_dn - dn0);
        end
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b0, 1'b1, HOLD);
        total++;
        if (n_up !== up0) begin
            bad++; $display("FAIL invalid_acc_early: got %0d pulses expected 0", n_up - up0);
        end
        drive_ab(1'b1, 1'b1, HOLD);
        total++;
        if (n_up !== exp_up || up_at !== T_STEP || dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL invalid_acc_kept: got up %0d at %0d digits %h expected %0d at %0d %h",
                            n_up, up_at, dut_digits(), exp_up, T_STEP, exp_digits(m_count));
        end
    endtask

    task automatic test_clear();
        int clr_at, guard;
        guard = 0;
        while (m_count != 42 && guard < 200) begin
            cw_detent();
            guard++;
        end
        total++;
        if (dut_digits() !== 16'h0042) begin
            bad++; $display("FAIL clear_setup: got %h expected 0042", dut_digits());
        end
        clr_at = -1;
        bus.enc_sw = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            @(posedge clk); #1;
            if (dut_digits() === 16'h0000 && clr_at < 0) clr_at = k;
        end
        m_count = 0;
        total++;
        if (clr_at !== 2 + int'(DB) + 1) begin
            bad++; $display("FAIL clear_latency: got %0d expected %0d", clr_at, 2 + DB + 1);
        end
        repeat (100) @(posedge clk);
        #1;
        cw_detent();
        total++;
        if (dut_digits() !== exp_digits(m_count) || n_wrap !== exp_wrap) begin
            bad++; $display("FAIL clear_held_retrigger: got %h wrap %0d expected %h wrap %0d",
                            dut_digits(), n_wrap, exp_digits(m_count), exp_wrap);
        end
        bus.enc_sw = 1'b1;
        repeat (HOLD) @(posedge clk);
        #1;
        total++;
        if (dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL clear_release: got %h expected %h", dut_digits(), exp_digits(m_count));
        end
    endtask

    task automatic test_clear_priority();
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b0, 1'b1, HOLD);
        // Final sub-step and press resolve together: the step pulse appears, count is cleared.
        bus.enc_a = 1'b1; bus.enc_b = 1'b1;
        @(posedge clk); #1;
        bus.enc_sw = 1'b0;
        repeat (HOLD) @(posedge clk);
        #1;
        m_acc = 0; m_a = 1'b1; m_b = 1'b1; exp_up++; m_count = 0;
        total++;
        if (dut_digits() !== 16'h0000 || n_up !== exp_up || n_wrap !== exp_wrap) begin
            bad++; $display("FAIL clear_priority: got %h up %0d wrap %0d expected 0000 up %0d wrap %0d",
                            dut_digits(), n_up, n_wrap, exp_up, exp_wrap);
        end
        bus.enc_sw = 1'b1;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int r, p, ch, len;
        logic [1:0] nab;
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 99));
            p = qpos(m_a, m_b);
            if (r < 40) begin
                nab = ab_of((p + 1) % 4);
                drive_ab(nab[1], nab[0], HOLD);
            end else if (r < 80) begin
                nab = ab_of((p + 3) % 4);
                drive_ab(nab[1], nab[0], HOLD);
            end else if (r < 88) begin
                nab = ab_of((p + 2) % 4);
                drive_ab(nab[1], nab[0], HOLD);
            end else if (r < 95) begin
                ch  = int'($urandom_range(0, 2));
                len = int'($urandom_range(1, 3));
                if (ch == 0) bus.enc_a = ~bus.enc_a;
                else if (ch == 1) bus.enc_b = ~bus.enc_b;
                else bus.enc_sw = ~bus.enc_sw;
                repeat (len) @(posedge clk);
                #1;
                bus.enc_a = m_a; bus.enc_b = m_b; bus.enc_sw = 1'b1;
                repeat (HOLD) @(posedge clk);
                #1;
            end else begin
                bus.enc_sw = 1'b0;
                repeat (HOLD) @(posedge clk);
                #1;
                m_count = 0;
                bus.enc_sw = 1'b1;
                repeat (HOLD) @(posedge clk);
                #1;
            end
            total++;
            if (dut_digits() !== exp_digits(m_count)) begin
                bad++; $display("FAIL random_digits it=%0d: got %h expected %h",
                                it, dut_digits(), exp_digits(m_count));
            end
        end
        total++;
        if (n_up !== exp_up || n_dn !== exp_dn || n_wrap !== exp_wrap) begin
            bad++; $display("FAIL random_pulse_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                            n_up, n_dn, n_wrap, exp_up, exp_dn, exp_wrap);
        end
        total++;
        if (n_wide !== 0 || n_both !== 0 || n_badbcd !== 0) begin
            bad++; $display("FAIL pulse_shape_bcd: got wide %0d both %0d badbcd %0d expected 0 0 0",
                            n_wide, n_both, n_badbcd);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        bus.enc_a = 1'b1; bus.enc_b = 1'b1; bus.enc_sw = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_count = 0; m_acc = 0; m_a = 1'b1; m_b = 1'b1;
    endtask

    task automatic test_reset_mid_detent();
        int up0;
        reset_pulse();
        repeat (HOLD) @(posedge clk);
        #1;
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        reset_pulse();
        total++;
        if (dut_digits() !== 16'h0000) begin
            bad++; $display("FAIL mid_reset_digits: got %h expected 0000", dut_digits());
        end
        repeat (HOLD) @(posedge clk);
        #1;
        up0 = n_up;
        drive_ab(1'b1, 1'b0, HOLD);
        drive_ab(1'b0, 1'b0, HOLD);
        drive_ab(1'b0, 1'b1, HOLD);
        total++;
        if (n_up !== up0) begin
            bad++; $display("FAIL mid_reset_early_step: got %0d pulses expected 0", n_up - up0);
        end
        drive_ab(1'b1, 1'b1, HOLD);
        total++;
        if (n_up !== up0 + 1 || up_at !== T_STEP || dut_digits() !== exp_digits(m_count)) begin
            bad++; $display("FAIL mid_reset_one_step: got %0d at %0d digits %h expected 1 at %0d %h",
                            n_up - up0, up_at, dut_digits(), T_STEP, exp_digits(m_count));
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_cw_detent();
        test_bounce();
        test_invalid();
        test_clear();
        test_clear_priority();
        test_random();
        test_reset_mid_detent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotary_bcd_counter.md
Name: rotary_bcd_counter

Overview:
- Upstream value source for the 7-segment scan stage: supplies the four BCD digits that the scan/serializer stage displays.
- Takes raw rotary-encoder inputs (quadrature A/B plus push switch), synchronizes and debounces them, and decodes direction.
- Maintains a 4-digit BCD up/down count 0000-9999 with wrap-around. The push switch clears the count.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive clk cycles an input must differ from its stable value before the stable value changes (1 ms at 100 MHz).
- STEPS_PER_DETENT, 4, valid quadrature sub-steps per counted step. Legal values: 1, 2, 4.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  synchronous, active-high reset
- enc_a  input  1  raw encoder channel A, asynchronous, idle high
- enc_b  input  1  raw encoder channel B, asynchronous, idle high
- enc_sw  input  1  raw push switch, asynchronous, active-low (0 = pressed)
- digit0  output  4  BCD units
- digit1  output  4  BCD tens
- digit2  output  4  BCD hundreds
- digit3  output  4  BCD thousands
- step_up  output  1  one-cycle pulse per counted CW step
- step_dn  output  1  one-cycle pulse per counted CCW step
- count_wrap  output  1  one-cycle pulse on a 9999->0000 or 0000->9999 transition

Behaviour:
- Reset is synchronous on the clk edge with rst=1. Reset values:
  - Synchronizer flops and debounced A/B/SW: 1.
  - Debounce counters, sub-step accumulator, prev-AB (=11): cleared.
  - digit0-3: 0. step_up, step_dn, count_wrap: 0.
- Synchronizer: a 2-FF chain per input. All later logic uses only the synchronized signals.
- Debounce, per input, independent:
  - If sync != stable, increment the counter. If sync == stable, clear the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync != stable, set stable <= sync and clear the counter.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Quadrature decode on debounced {A,B} versus prev-AB, evaluated every cycle, then prev-AB <= current:
  - CW sub-step (+1): 11->10, 10->00, 00->01, 01->11.
  - CCW sub-step (-1): 11->01, 01->00, 00->10, 10->11.
  - No change: nothing.
  - Double change (11<->00, 10<->01): invalid. Ignored; accumulator unchanged.
- Accumulator: signed, range -(STEPS_PER_DETENT-1)..+(STEPS_PER_DETENT-1).
  - Reaching +STEPS_PER_DETENT: step_up=1 for one cycle, accumulator <= 0.
  - Reaching -STEPS_PER_DETENT: step_dn=1 for one cycle, accumulator <= 0.
  - step_up and step_dn are never high in the same cycle.
- Step pulse timing: the pulse is registered and is high in the cycle after the debounced edge that completes the step.
- Counter updates in the same cycle step_up/step_dn is high; digits are visible on the next cycle.
  - Up: digit0+1. A digit of 9 becomes 0 and carries to the next digit. 9999 -> 0000 with count_wrap=1.
  - Down: digit0-1. A digit of 0 becomes 9 and borrows. 0000 -> 9999 with count_wrap=1.
  - Digits are always valid BCD (0-9). Values 10-15 never appear.
- Clear: a debounced SW 1->0 transition (press) sets all digits to 0 on the next cycle. count_wrap stays 0 on clear.
  - Release has no effect.
  - Holding the switch does not re-trigger.
- Priority when a press and a step resolve in the same cycle: clear wins; the step pulse is still emitted, but the count is not changed.
- Reset mid-detent: the partial accumulator is discarded, so the next full detent yields exactly one step.
- End-to-end latency from a raw input edge to a digit change: 2 (sync) + DEBOUNCE_CYCLES + 1 (decode/pulse) + 1 (count) cycles.

Test Plan (DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, each encoder state held 12 cycles unless stated):
- Reset: assert rst 3 cycles with A=B=SW=1 -> digits 0000; step_up, step_dn, count_wrap all 0; no pulses for 50 idle cycles.
- CW detent: drive AB 11->10->00->01->11 -> exactly one step_up pulse, one cycle wide; digits 0001. Ten such detents -> 0010, carry verified. One CCW detent (11->01->00->10->11) -> 0009 and one step_dn.
- Wrap: from 0000, one CCW detent -> 9999, count_wrap high exactly 1 cycle. Then one CW detent -> 0000, count_wrap high 1 cycle.
- Bounce rejection: toggle A every 2 cycles for 30 cycles, then return to 1 -> debounced A never changes; no step pulse; digits unchanged. Invalid jump AB 11->00 held, then back to 11 -> no pulse, accumulator unchanged.
- Clear: reach 0042, then pull SW low 12 cycles -> digits 0000 exactly 2+4+1 cycles after the SW edge. Keep SW low 100 cycles -> no further effect. Release -> no change.
- Reset mid-detent: drive 11->10->00, pulse rst 1 cycle, then drive a full CW detent from 11 -> exactly one step_up; digits 0001.
